// File: rtl/otter_cu_fsm_if.sv
// Bundle between the OTTER instruction register / interrupt logic and the control unit:
// instruction fields and intr toward the CU, per-cycle datapath enables back out.
interface otter_cu_fsm_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       intr;

  logic       pc_write;
  logic       reg_write;
  logic       mem_we2;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       rst_out;
  logic       csr_we;
  logic       int_taken;
  logic       mret_exec;
  logic [2:0] state_dbg;

  // The IR/interrupt side drives instruction fields and intr, then observes the enables.
  modport master (
    output opcode, func3, intr,
    input  pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
    input  rst_out, csr_we, int_taken, mret_exec, state_dbg
  );

  modport slave (
    input  opcode, func3, intr,
    output pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
    output rst_out, csr_we, int_taken, mret_exec, state_dbg
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// Multicycle OTTER control unit: INIT/FETCH/EXEC/WB/INTR sequencer that turns the
// current opcode/func3 (and intr) into the datapath write/read enables for each cycle.
module otter_cu_fsm #(
  parameter bit INTR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  otter_cu_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

  state_t state_q;
  state_t state_d;
  logic   intr_req;

  // intr only counts at the last state of an instruction; INTR itself never re-samples it.
  assign intr_req = INTR_EN && bus.intr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = ST_INIT;
    bus.pc_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_we2   = 1'b0;
    bus.mem_rden1 = 1'b0;
    bus.mem_rden2 = 1'b0;
    bus.rst_out   = 1'b0;
    bus.csr_we    = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;

    case (state_q)
      ST_INIT: begin
        bus.rst_out = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_FETCH: begin
        bus.mem_rden1 = 1'b1;
        state_d       = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = intr_req ? ST_INTR : ST_FETCH;
        case (bus.opcode)
          OPC_LOAD: begin
            // Loads finish in WB, so the PC must not move yet and intr waits too.
            bus.mem_rden2 = 1'b1;
            state_d       = ST_WB;
          end
          OPC_STORE: begin
            bus.mem_we2  = 1'b1;
            bus.pc_write = 1'b1;
          end
          OPC_BRANCH: begin
            bus.pc_write = 1'b1;
          end
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
            bus.pc_write  = 1'b1;
            bus.reg_write = 1'b1;
          end
          OPC_SYSTEM: begin
            bus.pc_write = 1'b1;
            case (bus.func3)
              F3_MRET: begin
                bus.mret_exec = 1'b1;
              end
              F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                bus.reg_write = 1'b1;
                bus.csr_we    = 1'b1;
              end
              default: begin
              end
            endcase
          end
          default: begin
            // Illegal opcodes retire as a NOP so the PC still advances.
            bus.pc_write = 1'b1;
          end
        endcase
      end

      ST_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        state_d       = intr_req ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        bus.int_taken = 1'b1;
        bus.pc_write  = 1'b1;
        state_d       = ST_FETCH;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: one DUT with interrupts enabled, one with INTR_EN=0.
module tb_otter_cu_fsm;

  // Output vector order: pc_write reg_write mem_we2 mem_rden1 mem_rden2 rst_out csr_we int_taken mret_exec
  localparam logic [8:0] O_NONE = 9'b000000000;
  localparam logic [8:0] O_PC   = 9'b100000000;
  localparam logic [8:0] O_RW   = 9'b010000000;
  localparam logic [8:0] O_WE2  = 9'b001000000;
  localparam logic [8:0] O_RD1  = 9'b000100000;
  localparam logic [8:0] O_RD2  = 9'b000010000;
  localparam logic [8:0] O_RST  = 9'b000001000;
  localparam logic [8:0] O_CSR  = 9'b000000100;
  localparam logic [8:0] O_INT  = 9'b000000010;
  localparam logic [8:0] O_MRET = 9'b000000001;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_INTR  = 3'd4;

  logic clk;
  logic reset;
  logic reset2;
  int   n_vec;
  int   n_err;

  otter_cu_fsm_if bus ();
  otter_cu_fsm_if bus2 ();

  otter_cu_fsm #(.INTR_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  otter_cu_fsm #(.INTR_EN(1'b0)) dut2 (.clk(clk), .reset(reset2), .bus(bus2.slave));

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] outs1();
    return {bus.pc_write, bus.reg_write, bus.mem_we2, bus.mem_rden1, bus.mem_rden2,
            bus.rst_out, bus.csr_we, bus.int_taken, bus.mret_exec};
  endfunction

  function automatic logic [8:0] outs2();
    return {bus2.pc_write, bus2.reg_write, bus2.mem_we2, bus2.mem_rden1, bus2.mem_rden2,
            bus2.rst_out, bus2.csr_we, bus2.int_taken, bus2.mret_exec};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic irq);
    bus.opcode = opc;
    bus.func3  = f3;
    bus.intr   = irq;
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st_obs, input logic [2:0] st_exp,
                     input logic [8:0] o_obs, input logic [8:0] o_exp);
    n_vec++;
    assert ({st_obs, o_obs} === {st_exp, o_exp})
    else begin
      n_err++;
      $error("FAIL %s: observed state=%0d outs=%b, expected state=%0d outs=%b",
             tag, st_obs, o_obs, st_exp, o_exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [2:0] st_exp, input logic [8:0] o_exp);
    chk(tag, bus.state_dbg, st_exp, outs1(), o_exp);
  endtask

  task automatic chk2(input string tag, input logic [2:0] st_exp, input logic [8:0] o_exp);
    chk(tag, bus2.state_dbg, st_exp, outs2(), o_exp);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    reset2       = 1'b1;
    bus2.opcode  = 7'b0110011;
    bus2.func3   = 3'b000;
    bus2.intr    = 1'b1;
    drive(7'b0110011, 3'b000, 1'b0);

    // reset held for three edges
    tick(); chk1("reset_c1", S_INIT, O_RST);
    tick(); chk1("reset_c2", S_INIT, O_RST);
    tick(); chk1("reset_c3", S_INIT, O_RST);
    chk2("dut2_held_reset", S_INIT, O_RST);
    reset = 1'b0;
    #1;
    chk1("init_after_release", S_INIT, O_RST);
    tick(); chk1("first_fetch", S_FETCH, O_RD1);

    // OP: two-cycle period
    tick(); chk1("op_exec", S_EXEC, O_PC | O_RW);
    tick(); chk1("op_fetch2", S_FETCH, O_RD1);

    // LOAD: three-cycle period
    drive(7'b0000011, 3'b010, 1'b0);
    tick(); chk1("load_exec", S_EXEC, O_RD2);
    tick(); chk1("load_wb", S_WB, O_PC | O_RW);
    tick(); chk1("load_fetch", S_FETCH, O_RD1);

    // STORE with intr raised in EXEC, held through INTR (ignored there)
    drive(7'b0100011, 3'b010, 1'b0);
    tick(); chk1("store_exec", S_EXEC, O_WE2 | O_PC);
    drive(7'b0100011, 3'b010, 1'b1);
    chk1("store_exec_intr", S_EXEC, O_WE2 | O_PC);
    tick(); chk1("intr_entry", S_INTR, O_INT | O_PC);
    tick(); chk1("intr_to_fetch", S_FETCH, O_RD1);
    drive(7'b1110011, 3'b000, 1'b0);

    // SYSTEM variants, branch and illegal opcode
    tick(); chk1("mret_exec", S_EXEC, O_MRET | O_PC);
    tick(); chk1("mret_fetch", S_FETCH, O_RD1);
    drive(7'b1110011, 3'b001, 1'b0);
    tick(); chk1("csrrw_exec", S_EXEC, O_CSR | O_RW | O_PC);
    tick();
    drive(7'b1110011, 3'b011, 1'b0);
    tick(); chk1("csrrc_exec", S_EXEC, O_CSR | O_RW | O_PC);
    tick();
    drive(7'b1110011, 3'b100, 1'b0);
    tick(); chk1("sys_other_f3", S_EXEC, O_PC);
    tick();
    drive(7'b1111111, 3'b000, 1'b0);
    tick(); chk1("illegal_exec", S_EXEC, O_PC);
    tick();
    drive(7'b1100011, 3'b000, 1'b0);
    tick(); chk1("branch_exec", S_EXEC, O_PC);
    tick(); chk1("branch_fetch", S_FETCH, O_RD1);

    // intr pulse only during FETCH is lost
    drive(7'b0010011, 3'b000, 1'b1);
    tick();
    drive(7'b0010011, 3'b000, 1'b0);
    chk1("opimm_exec_pulse_lost", S_EXEC, O_PC | O_RW);
    tick(); chk1("pulse_lost_fetch", S_FETCH, O_RD1);

    // LOAD with intr held: ignored in EXEC, taken after WB
    drive(7'b0000011, 3'b000, 1'b1);
    tick(); chk1("load_intr_exec", S_EXEC, O_RD2);
    tick(); chk1("load_intr_wb", S_WB, O_PC | O_RW);
    tick(); chk1("load_intr_entry", S_INTR, O_INT | O_PC);
    drive(7'b0000011, 3'b000, 1'b0);
    tick(); chk1("load_intr_fetch", S_FETCH, O_RD1);

    // reset mid-LOAD: EXEC outputs still from old state, then INIT, no WB
    tick(); chk1("load_rst_exec", S_EXEC, O_RD2);
    reset = 1'b1;
    #1;
    chk1("load_rst_same_cycle", S_EXEC, O_RD2);
    tick(); chk1("load_rst_init", S_INIT, O_RST);
    reset = 1'b0;
    tick(); chk1("load_rst_refetch", S_FETCH, O_RD1);

    // INTR_EN=0 with intr held high: INTR never entered
    reset2 = 1'b0;
    tick(); chk2("dut2_fetch", S_FETCH, O_RD1);
    tick(); chk2("dut2_exec", S_EXEC, O_PC | O_RW);
    tick(); chk2("dut2_no_intr", S_FETCH, O_RD1);
    bus2.opcode = 7'b0000011;
    tick(); chk2("dut2_load_exec", S_EXEC, O_RD2);
    tick(); chk2("dut2_load_wb", S_WB, O_PC | O_RW);
    tick(); chk2("dut2_wb_no_intr", S_FETCH, O_RD1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
